rnn_weight_store: RTL

//  Runtime-loadable RNN weight memory. Replaces hard-wired weight constants.

---
 rtl/rnn_pkg.sv | 19 +
 rtl/rnn_weight_ram.sv | 34 +++
 rtl/rnn_weight_store.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/rnn_pkg.sv
// Shared types and default sizing for the RNN weight store.
//   DEF_DATA_W / DEF_ROWS / DEF_COLS : default weight width and matrix shape
//   weight_t                         : one signed fixed-point weight at default width
//   ws_state_e                       : control FSM states
package rnn_pkg;

    localparam int unsigned DEF_DATA_W = 16;
    localparam int unsigned DEF_ROWS   = 4;
    localparam int unsigned DEF_COLS   = 32;

    typedef logic signed [DEF_DATA_W-1:0] weight_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        READ = 2'd2
    } ws_state_e;

endpackage

// File: rtl/rnn_weight_ram.sv
// 1R1W synchronous RAM holding the weight matrix. Only the read data
// register is reset; the array contents are left untouched by reset.
//   clk, rst_n   : clock, async active-low reset (read register only)
//   we/waddr/wdata : write port
//   re/raddr     : read port; rdata updates one cycle after re, holds otherwise
module rnn_weight_ram #(
    parameter int unsigned W     = 16,
    parameter int unsigned DEPTH = 128,
    parameter int unsigned AW    = 7
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem [DEPTH];

    // Write port
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    // Read port; rdata doubles as the output stage, so it holds when re is low
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)  rdata <= '0;
        else if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/rnn_weight_store.sv
// Runtime-loadable RNN weight memory: a row-major load stream fills the
// matrix, then any row streams out one word per beat under valid/ready.
// Optional macro RNN_WEIGHT_PARITY_EN adds one even-parity bit per word,
// checked on every valid output beat (sticky par_err); otherwise par_err = 0.
//   load_start, wr_valid, wr_ready, wr_data : matrix load interface
//   loaded                                  : full matrix present
//   rd_start, rd_row, rd_err                : row stream request / rejection
//   busy                                    : FSM not idle
//   out_valid, out_ready, out_data, out_col, out_last : row output stream
//   par_err                                 : sticky parity error
module rnn_weight_store
    import rnn_pkg::*;
#(
    parameter  int unsigned DATA_W = DEF_DATA_W,
    parameter  int unsigned ROWS   = DEF_ROWS,
    parameter  int unsigned COLS   = DEF_COLS,
    localparam int unsigned DEPTH  = ROWS * COLS,
    localparam int unsigned AW     = $clog2(DEPTH),
    localparam int unsigned RW     = $clog2(ROWS),
    localparam int unsigned CW     = $clog2(COLS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_start,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [DATA_W-1:0] wr_data,
    output logic              loaded,
    input  logic              rd_start,
    input  logic [RW-1:0]     rd_row,
    output logic              rd_err,
    output logic              busy,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CW-1:0]     out_col,
    output logic              out_last,
    output logic              par_err
);

`ifdef RNN_WEIGHT_PARITY_EN
    localparam int unsigned RAM_W = DATA_W + 1;
`else
    localparam int unsigned RAM_W = DATA_W;
`endif

    ws_state_e         state, state_nxt;
    logic [AW-1:0]     wr_ptr;
    logic [RW-1:0]     rd_base;
    logic [CW-1:0]     rd_col;
    logic              rd_issued_all;
    logic [RAM_W-1:0]  ram_wdata, ram_rdata;
    logic [AW-1:0]     ram_raddr_c;

    logic load_go_c, rd_go_c, rd_rej_c, rd_req_c, row_ok_c;
    logic wr_fire_c, wr_last_c, rd_fire_c, out_done_c;

    // Handshake and request decode
    always_comb begin
        row_ok_c    = 32'(rd_row) < ROWS;
        load_go_c   = load_start && (state != READ);
        rd_req_c    = rd_start && (state == IDLE) && !load_start;
        rd_go_c     = rd_req_c && loaded && row_ok_c;
        rd_rej_c    = rd_req_c && !(loaded && row_ok_c);
        wr_fire_c   = (state == LOAD) && wr_valid && wr_ready && !load_start;
        wr_last_c   = wr_fire_c && (wr_ptr == AW'(DEPTH - 1));
        // Issue a read whenever the output stage is empty or being drained
        rd_fire_c   = (state == READ) && !rd_issued_all && (!out_valid || out_ready);
        out_done_c  = (state == READ) && out_valid && out_ready && out_last;
        ram_raddr_c = AW'(32'(rd_base) * COLS + 32'(rd_col));
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (load_go_c)    state_nxt = LOAD;
                else if (rd_go_c) state_nxt = READ;
            end
            LOAD: begin
                if (load_start)     state_nxt = LOAD;
                else if (wr_last_c) state_nxt = IDLE;
            end
            READ: begin
                if (out_done_c) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Registered status, pointers and output-stage sideband
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ready      <= 1'b0;
            busy          <= 1'b0;
            rd_err        <= 1'b0;
            loaded        <= 1'b0;
            wr_ptr        <= '0;
            rd_base       <= '0;
            rd_col        <= '0;
            rd_issued_all <= 1'b0;
            out_valid     <= 1'b0;
            out_col       <= '0;
            out_last      <= 1'b0;
        end else begin
            wr_ready <= (state_nxt == LOAD);
            busy     <= (state_nxt != IDLE);
            rd_err   <= rd_rej_c;

            if (load_go_c) begin
                wr_ptr <= '0;
                loaded <= 1'b0;
            end else if (wr_fire_c) begin
                wr_ptr <= wr_ptr + AW'(1);
                if (wr_last_c) loaded <= 1'b1;
            end

            if (rd_go_c) begin
                rd_base       <= rd_row;
                rd_col        <= '0;
                rd_issued_all <= 1'b0;
            end else if (rd_fire_c) begin
                rd_col        <= rd_col + CW'(1);
                rd_issued_all <= (rd_col == CW'(COLS - 1));
            end

            // Sideband moves in lockstep with the RAM read register
            if (rd_fire_c) begin
                out_valid <= 1'b1;
                out_col   <= rd_col;
                out_last  <= (rd_col == CW'(COLS - 1));
            end else if (out_ready) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end
        end
    end

`ifdef RNN_WEIGHT_PARITY_EN
    assign ram_wdata = {^wr_data, wr_data};

    // Even parity over data+parity must be zero on every valid beat
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                       par_err <= 1'b0;
        else if (load_go_c)               par_err <= 1'b0;
        else if (out_valid && ^ram_rdata) par_err <= 1'b1;
    end
`else
    assign ram_wdata = wr_data;
    assign par_err   = 1'b0;
`endif

    assign out_data = ram_rdata[DATA_W-1:0];

    rnn_weight_ram #(
        .W     (RAM_W),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (wr_fire_c),
        .waddr (wr_ptr),
        .wdata (ram_wdata),
        .re    (rd_fire_c),
        .raddr (ram_raddr_c),
        .rdata (ram_rdata)
    );

endmodule
